cla_pipe_addsub: RTL and testbench
==================================

# cla_pipe_addsub

Parametrised, pipelined carry-look-ahead adder/subtractor built from 4-bit look-ahead groups, with one pipeline register after every GROUPS_PER_STAGE groups. It is the wide-operand successor to the team's single-cycle 4-bit CLA and adds add/subtract mode, signed-overflow detection, and a valid/ready stream interface with backpressure. It sits between operand-producing logic and any consumer that can tolerate fixed latency in exchange for clock rate.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of 4 and ≥ 4.
- GROUPS_PER_STAGE, 2: number of 4-bit CLA groups evaluated per pipeline stage; must divide WIDTH/4.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry-out (add) / NOT borrow-out (sub).
- ovf  output  1  two's-complement signed overflow.

## Operation
- NSTAGES = WIDTH / (4·GROUPS_PER_STAGE). Example: WIDTH=16, GROUPS_PER_STAGE=1 gives NSTAGES=4.
- Effective operands:
  - add: B' = b, c0 = cin, result a + b + cin.
  - sub: B' = ~b, c0 = ~cin, result a − b − cin.
- Inside each 4-bit group: p = a^B', g = a&B'. Group carries come from the full look-ahead equations c1..c4, with no ripple inside the group. Group sum = p ^ c.
- Groups in the same stage chain their group carry-out combinationally.
- Stage k handles groups k·GPS .. k·GPS+GPS−1.
- Stage k registers the following:
  - its own sum slice;
  - the sum slices of all lower stages, carried forward;
  - the unprocessed upper bits of a and B';
  - the stage carry-out;
  - a valid bit.
- The final stage produces:
  - sum;
  - cout = carry out of bit WIDTH−1;
  - ovf = carry into bit WIDTH−1 XOR carry out of bit WIDTH−1.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
- Stall model is a global stall: stall = out_valid && !out_ready, and in_ready = !stall. While stalled, every pipeline register, including valid bits, holds.
- Bubbles (in_valid=0 while not stalled) advance as valid=0 entries. Data registers may load don't-care values when valid=0.
- sum, cout and ovf are meaningful only while out_valid=1. They are stable for the whole time out_valid && !out_ready.

## Timing
- Reset, synchronous: every stage valid bit is 0, and all data registers, sum, cout and ovf are 0.
  - Reset has priority over stall and over an accepted beat in the same cycle.
  - Reset asserted mid-operation discards all in-flight beats. No beat in flight at reset ever appears on the output.
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+NSTAGES−1. The final stage register is the output register, so latency is NSTAGES cycles from the accepting edge to the result being visible.
- Throughput is one beat per cycle when out_ready stays 1.
- in_ready is combinational from out_valid and out_ready. No other combinational input-to-output path exists.
- Simultaneous consume and accept: when out_valid && out_ready && in_valid, the pipeline advances, the output beat retires, and the new beat enters stage 0 in the same cycle.
- When out_ready=1 and the pipeline is empty, in_ready stays 1.
- Boundary arithmetic:
  - all-ones + 1 wraps to 0 with cout=1.
  - 0 − 1 gives all-ones with cout=0 (borrow).
  - The carry crossing every stage boundary must be correct, including a full-length propagate chain.

## Test plan
All cases use WIDTH=16, GROUPS_PER_STAGE=1, so NSTAGES=4.
- Reset/latency: reset for 2 cycles, then release; out_valid=0. Send a=0x1234, b=0x1111, cin=0, sub=0. Required: out_valid rises 4 cycles after acceptance with sum=0x2345, cout=0, ovf=0.
- Full propagate chain: a=0xFFFF, b=0x0000, cin=1, add. Required: sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001, cin=0. Required: sum=0x8000, cout=0, ovf=1.
- Subtract:
  - a=0x0000, b=0x0001, cin=0, sub=1 → sum=0xFFFF, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
  - a=0x0005, b=0x0003, cin=1, sub=1 → sum=0x0001, cout=1.
- Backpressure: stream 8 back-to-back beats, and hold out_ready=0 for 3 cycles once the first result arrives. Required:
  - in_ready=0 for exactly those cycles;
  - output stable throughout;
  - all 8 results emitted in order, none lost or duplicated.
- Bubbles and simultaneous events: alternate in_valid 1/0 with out_ready toggling every cycle. Required: in-order results match a reference model, and beats are accepted on the same cycle a result retires.
- Mid-flight reset: accept 3 beats, then assert rst for 1 cycle. Required: out_valid=0 and all outputs 0 on the next cycle, no stale result ever emitted, and a following beat returns its correct result with 4-cycle latency.

Source files
------------

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined carry-look-ahead adder/subtractor.
// 4-bit look-ahead groups, one register stage per GROUPS_PER_STAGE groups.
module cla_pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int GROUPS_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int GPS = GROUPS_PER_STAGE;
  localparam int SW = 4 * GPS;
  localparam int NSTAGES = WIDTH / SW;

  // One 4-bit group: returns {carry into bit 3, group carry-out, sum}.
  function automatic logic [5:0] cla4(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [3:0] p;
    logic [3:0] g;
    logic c1, c2, c3, c4;
    p = x ^ y;
    g = x & y;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
       | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c3, c4, p ^ {c3, c2, c1, ci}};
  endfunction

  // Stage registers: operands still to process, finished sum bits,
  // stage carry-out and valid.
  logic [WIDTH-1:0] r_a [NSTAGES];
  logic [WIDTH-1:0] r_b [NSTAGES];
  logic [WIDTH-1:0] r_s [NSTAGES];
  logic             r_c [NSTAGES];
  logic             r_v [NSTAGES];
  logic             r_ovf;

  // Stage inputs and next-state values.
  logic [WIDTH-1:0] x_a [NSTAGES];
  logic [WIDTH-1:0] x_b [NSTAGES];
  logic [WIDTH-1:0] x_s [NSTAGES];
  logic             x_c [NSTAGES];
  logic [WIDTH-1:0] n_s [NSTAGES];
  logic             n_c [NSTAGES];
  logic             n_ovf;

  logic stall;

  assign stall = r_v[NSTAGES-1] & ~out_ready;
  assign in_ready = ~stall;

  assign out_valid = r_v[NSTAGES-1];
  assign sum = r_s[NSTAGES-1];
  assign cout = r_c[NSTAGES-1];
  assign ovf = r_ovf;

  // Select each stage's inputs: stage 0 from the ports, others from
  // the previous stage register. Subtract inverts b and the carry-in.
  always_comb begin
    x_a[0] = a;
    x_b[0] = sub ? ~b : b;
    x_s[0] = '0;
    x_c[0] = cin ^ sub;
    for (int k = 1; k < NSTAGES; k++) begin
      x_a[k] = r_a[k-1];
      x_b[k] = r_b[k-1];
      x_s[k] = r_s[k-1];
      x_c[k] = r_c[k-1];
    end
  end

  // Evaluate this stage's groups, chaining group carries combinationally.
  always_comb begin
    logic [WIDTH-1:0] s;
    logic             c;
    logic             c_top;
    logic [5:0]       t;
    int               idx;
    s = '0;
    c = 1'b0;
    c_top = 1'b0;
    t = '0;
    idx = 0;
    n_ovf = 1'b0;
    for (int k = 0; k < NSTAGES; k++) begin
      s = x_s[k];
      c = x_c[k];
      for (int g = 0; g < GPS; g++) begin
        idx = (k * GPS + g) * 4;
        t = cla4(x_a[k][idx +: 4], x_b[k][idx +: 4], c);
        s[idx +: 4] = t[3:0];
        c = t[4];
        c_top = t[5];
      end
      n_s[k] = s;
      n_c[k] = c;
    end
    n_ovf = c_top ^ c;
  end

  // Advance the whole pipeline unless the output is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NSTAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
        r_v[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < NSTAGES; k++) begin
        r_a[k] <= x_a[k];
        r_b[k] <= x_b[k];
        r_s[k] <= n_s[k];
        r_c[k] <= n_c[k];
      end
      r_v[0] <= in_valid;
      for (int k = 1; k < NSTAGES; k++) begin
        r_v[k] <= r_v[k-1];
      end
      r_ovf <= n_ovf;
    end
  end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// tb_cla_pipe_addsub: scoreboard bench for cla_pipe_addsub.
// WIDTH=16, GROUPS_PER_STAGE=1, four stages.
module tb_cla_pipe_addsub;

  localparam int W = 16;
  localparam int NST = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  cla_pipe_addsub #(.WIDTH(W), .GROUPS_PER_STAGE(1)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .sub(sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .ovf(ovf)
  );

  typedef struct {
    logic [17:0] res;
    int          acc;
    int          sc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int sc = 0;
  int n_out = 0;
  int n_sim = 0;
  int mode = 0;
  logic prev_stall = 0;
  logic was_rst = 0;
  logic [17:0] held = '0;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event, required none (cycle %0d)", nm, cyc);
  endtask

  // Reference: plain integer arithmetic, returns {sum, cout, ovf}.
  function automatic logic [17:0] model(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic ci, input logic s);
    int ua, ub, sa, sb, c, r, rs;
    logic co, ov;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sb = int'($signed(y));
    c = ci ? 1 : 0;
    if (!s) begin
      r = ua + ub + c;
      rs = sa + sb + c;
      co = (r > 65535);
    end else begin
      r = ua - ub - c;
      rs = sa - sb - c;
      co = (r >= 0);
    end
    ov = (rs > 32767) || (rs < -32768);
    return {r[15:0], co, ov};
  endfunction

  always @(posedge clk) cyc++;

  // Output-ready driver
  always @(posedge clk) begin
    #1;
    case (mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = ($urandom_range(0, 3) != 0);
      default: ;
    endcase
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic stall_now;
    exp_t e;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
      was_rst = 1'b1;
    end else begin
      if (was_rst) begin
        check("reset_outputs", {13'd0, out_valid, cout, ovf, sum}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        was_rst = 1'b0;
      end
      stall_now = out_valid && !out_ready;
      check("in_ready", {31'd0, in_ready}, {31'd0, !stall_now});
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_data", {14'd0, sum, cout, ovf}, {14'd0, held});
      end else if (out_valid) begin
        if (q.size() == 0) fail("stale_output");
        else check("latency", cyc - q[0].acc, NST + sc - q[0].sc);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          fail("unexpected_result");
        end else begin
          e = q.pop_front();
          check("result", {14'd0, sum, cout, ovf}, {14'd0, e.res});
          n_out++;
          if (in_valid && in_ready) n_sim++;
        end
      end
      if (in_valid && in_ready)
        q.push_back('{res: model(a, b, cin, sub), acc: cyc, sc: sc});
      if (stall_now) sc++;
      prev_stall = stall_now;
      held = {sum, cout, ovf};
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic ci, input logic s);
    logic acc;
    int n;
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = ci;
    sub = s;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) fail("accept_timeout");
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] rval();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'hFFFF;
      1: v = 16'h0000;
      2: v = 16'h8000;
      3: v = 16'h7FFF;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  task automatic send_rand();
    send(rval(), rval(), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    int base_out;
    int base_sim;
    logic got;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    idle(6);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0000, 16'h0001, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h0005, 16'h0003, 1'b1, 1'b1);
    idle(8);

    mode = 3;
    out_ready = 1'b1;
    base_out = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
        idle(1);
      end
      begin
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
          @(posedge clk);
          #1;
          got = out_valid;
        end
        if (!got) fail("bp_wait_timeout");
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_high", {31'd0, in_ready}, 32'd1);
      end
    join
    mode = 0;
    idle(12);
    check("bp_count", n_out - base_out, 8);

    base_sim = n_sim;
    mode = 1;
    for (int i = 0; i < 24; i++) begin
      send_rand();
      idle(1);
    end
    idle(12);
    mode = 0;
    idle(4);
    check("simultaneous_seen", {31'd0, (n_sim > base_sim)}, 32'd1);

    for (int i = 0; i < 3; i++) send_rand();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle(6);
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    idle(8);

    mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send_rand();
    end
    in_valid = 1'b0;
    mode = 0;
    idle(12);
    check("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
